// File: rtl/seg7_serial_display.sv
// Serial seven-segment display driver.
// Snapshots DIGITS hex nibbles (or raw segment bytes) plus decimal points,
// encodes them into an 8*DIGITS-bit frame and shifts it out over s_clk/sout.
// A new frame is sent periodically (REFRESH_CYCLES) and on each update request.
// Optional build macro SEG_LZB_EN enables leading-zero blanking in hex mode.
module seg7_serial_display #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned DIV            = 2,
  parameter int unsigned REFRESH_CYCLES = 65536,
  parameter int unsigned DIR            = 0,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dot_in,
  input  logic                  raw_mode,
  input  logic [8*DIGITS-1:0]   raw_seg,
  input  logic                  update,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  s_clk,
  output logic                  s_clrn,
  output logic                  sout,
  output logic                  EN
);

  localparam int unsigned FrameBits = 8 * DIGITS;
  localparam int unsigned BitCntW   = $clog2(FrameBits);
  localparam int unsigned DivCntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RefCntW   = $clog2(REFRESH_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftLo,
    StShiftHi,
    StLatch
  } state_e;

  state_e               state_q, state_d;
  logic [FrameBits-1:0] frame_q;
  logic [FrameBits-1:0] frame_build;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [DivCntW-1:0]   div_cnt_q;
  logic [RefCntW-1:0]   ref_cnt_q;
  logic                 pending_q;
  logic                 frame_seen_q;
  logic                 div_last;
  logic                 bit_last;
  logic                 ref_wrap;
  logic                 enter_load;
  logic                 cur_bit;
  logic [7:0]           seg_byte;
  logic [3:0]           nib;

  // Hex digit to active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

  assign div_last   = (div_cnt_q == DivCntW'(DIV - 1));
  assign bit_last   = (bit_cnt_q == BitCntW'(FrameBits - 1));
  assign ref_wrap   = (ref_cnt_q == RefCntW'(REFRESH_CYCLES - 1));
  assign enter_load = (state_q == StIdle) && pending_q;
  // Frame is kept in display order; DIR only selects which end leaves first
  assign cur_bit    = (DIR == 0) ? frame_q[FrameBits-1] : frame_q[0];

`ifdef SEG_LZB_EN
  logic blank_run;
`endif

  // Encode the live inputs into a frame; captured only in LOAD
  always_comb begin
    frame_build = '0;
    seg_byte    = '0;
    nib         = '0;
`ifdef SEG_LZB_EN
    blank_run   = 1'b1;
`endif
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib = data_in[4*i +: 4];
      if (raw_mode) begin
        seg_byte = raw_seg[8*i +: 8];
      end else begin
        seg_byte = {dot_in[i], hex_to_seg(nib)};
`ifdef SEG_LZB_EN
        // Blank leading zero digits from the top; digit 0 always shows
        if (blank_run && (i != 0) && (nib == 4'h0) && !dot_in[i]) begin
          seg_byte = 8'h00;
        end else begin
          blank_run = 1'b0;
        end
`endif
      end
      if (SEG_ACTIVE_LOW != 0) begin
        seg_byte = ~seg_byte;
      end
      frame_build[8*i +: 8] = seg_byte;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (pending_q) state_d = StLoad;
      StLoad:    state_d = StShiftLo;
      StShiftLo: if (div_last) state_d = StShiftHi;
      StShiftHi: if (div_last) state_d = bit_last ? StLatch : StShiftLo;
      StLatch:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output decode; reset forces every output to its idle value in the same cycle
  always_comb begin
    busy       = (state_q != StIdle);
    frame_done = (state_q == StLatch);
    s_clk      = (state_q == StShiftHi);
    sout       = ((state_q == StShiftLo) || (state_q == StShiftHi)) ? cur_bit : 1'b0;
    EN         = ((state_q == StIdle) && frame_seen_q) || (state_q == StLatch);
    s_clrn     = 1'b1;
    if (rst) begin
      busy       = 1'b0;
      frame_done = 1'b0;
      s_clk      = 1'b0;
      sout       = 1'b0;
      EN         = 1'b0;
      s_clrn     = 1'b0;
    end
  end

  // Bit timing, frame shift register and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
    end else begin
      if ((state_q == StShiftLo) || (state_q == StShiftHi)) begin
        div_cnt_q <= div_last ? '0 : div_cnt_q + DivCntW'(1);
      end else begin
        div_cnt_q <= '0;
      end
      if (state_q == StLoad) begin
        bit_cnt_q <= '0;
        frame_q   <= frame_build;
      end else if ((state_q == StShiftHi) && div_last) begin
        bit_cnt_q <= bit_cnt_q + BitCntW'(1);
        frame_q   <= (DIR == 0) ? {frame_q[FrameBits-2:0], 1'b0}
                                : {1'b0, frame_q[FrameBits-1:1]};
      end
    end
  end

  // Refresh timer and request coalescing; a new request wins over the LOAD clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q    <= '0;
      pending_q    <= 1'b1;
      frame_seen_q <= 1'b0;
    end else begin
      ref_cnt_q    <= ref_wrap ? '0 : ref_cnt_q + RefCntW'(1);
      pending_q    <= (pending_q && !enter_load) || update || ref_wrap;
      if (state_q == StLatch) begin
        frame_seen_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_serial_display.sv
// Bench for seg7_serial_display: two instances (DIR=0/active-high and
// DIR=1/active-low) share stimulus; a monitor reassembles each serial frame
// and checks it against expected frames queued when stimulus is driven.
module tb_seg7_serial_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [7:0]  dot_in;
  logic        raw_mode;
  logic [63:0] raw_seg;
  logic        update;

  logic busy0, fd0, sclk0, sclrn0, sout0, en0;
  logic busy1, fd1, sclk1, sclrn1, sout1, en1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] cap[2];
  int          nbits[2];
  int          done_cnt[2];
  logic        prev_sclk[2];

  always #5 clk = ~clk;

  seg7_serial_display #(
    .DIGITS(8), .DIV(2), .REFRESH_CYCLES(65536), .DIR(0), .SEG_ACTIVE_LOW(0)
  ) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .dot_in(dot_in), .raw_mode(raw_mode),
    .raw_seg(raw_seg), .update(update), .busy(busy0), .frame_done(fd0), .s_clk(sclk0),
    .s_clrn(sclrn0), .sout(sout0), .EN(en0)
  );

  seg7_serial_display #(
    .DIGITS(8), .DIV(2), .REFRESH_CYCLES(65536), .DIR(1), .SEG_ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .dot_in(dot_in), .raw_mode(raw_mode),
    .raw_seg(raw_seg), .update(update), .busy(busy1), .frame_done(fd1), .s_clk(sclk1),
    .s_clrn(sclrn1), .sout(sout1), .EN(en1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stream as captured (first bit at MSB) for a frame sent LSB first
  function automatic logic [63:0] rev64(input logic [63:0] v);
    logic [63:0] r;
    for (int b = 0; b < 64; b++) r[b] = v[63-b];
    return r;
  endfunction

  // Reassemble frames on s_clk rising edges; compare at frame_done
  always @(negedge clk) begin
    logic [1:0] sc, so, fd;
    logic [63:0] e;
    sc = {sclk1, sclk0};
    so = {sout1, sout0};
    fd = {fd1, fd0};
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cap[k] = '0;
        nbits[k] = 0;
        prev_sclk[k] = 1'b0;
      end else begin
        if (sc[k] && !prev_sclk[k]) begin
          cap[k] = {cap[k][62:0], so[k]};
          nbits[k]++;
        end
        prev_sclk[k] = sc[k];
        if (fd[k]) begin
          done_cnt[k]++;
          if (k == 0) e = (q0.size() > 0) ? q0.pop_front() : 64'hx;
          else        e = (q1.size() > 0) ? q1.pop_front() : 64'hx;
          chk((k == 0) ? "frame_dut0" : "frame_dut1", cap[k], e);
          chk((k == 0) ? "nbits_dut0" : "nbits_dut1", 64'(nbits[k]), 64'd64);
          cap[k] = '0;
          nbits[k] = 0;
        end
      end
    end
  end

  task automatic push_exp(input logic [63:0] e0, input logic [63:0] e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic pulse_update();
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt[0] < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_frame_done", 64'(done_cnt[0] >= target), 64'd1);
  endtask

  initial begin
    logic [63:0] e2, e3, e4, e5, e6;
    int cyc, start, t;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    rst      = 1'b1;
    update   = 1'b0;
    raw_mode = 1'b0;
    raw_seg  = '0;
    data_in  = 32'h0000_0001;
    dot_in   = 8'h00;
`ifdef SEG_LZB_EN
    e2 = 64'h0000_0000_0000_0006;
`else
    e2 = 64'h3F3F_3F3F_3F3F_3F06;
`endif
    push_exp(e2, rev64(~e2));
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_frame_done", 64'(fd0), 64'd0);
    chk("rst_s_clk", 64'(sclk0), 64'd0);
    chk("rst_s_clrn", 64'(sclrn0), 64'd0);
    chk("rst_sout", 64'(sout0), 64'd0);
    chk("rst_en", 64'(en0), 64'd0);
    rst = 1'b0;

    // First frame: LOAD on the first cycle after release, LATCH 258 cycles later
    @(negedge clk);
    chk("load_busy", 64'(busy0), 64'd1);
    chk("load_en", 64'(en0), 64'd0);
    chk("load_s_clrn", 64'(sclrn0), 64'd1);
    cyc = 1;
    while (!fd0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd258);
    @(negedge clk);
    chk("idle_en", 64'(en0), 64'd1);
    chk("idle_busy", 64'(busy0), 64'd0);

    // Hex with dot, reversed/inverted on dut1
    data_in = 32'h89AB_CDEF;
    dot_in  = 8'h01;
    e3 = 64'h7F6F_777C_395E_79F1;
    push_exp(e3, rev64(64'h8090_8883_C6A1_860E));
    start = done_cnt[0];
    pulse_update();
    wait_done(start + 1);

    // Three updates during a frame coalesce into one extra frame
    data_in = 32'h1234_5678;
    dot_in  = 8'h00;
    e4 = 64'h065B_4F66_6D7D_077F;
    push_exp(e4, rev64(~e4));
    push_exp(e4, rev64(~e4));
    start = done_cnt[0];
    pulse_update();
    repeat (10) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      pulse_update();
      repeat (20) @(negedge clk);
    end
    wait_done(start + 2);
    repeat (300) @(negedge clk);
    chk("coalesce_frames", 64'(done_cnt[0] - start), 64'd2);
    chk("coalesce_idle", 64'(busy0), 64'd0);

    // Raw mode: dots ignored, bytes sent as given
    raw_mode = 1'b1;
    raw_seg  = 64'h0102_0408_1020_4080;
    dot_in   = 8'hFF;
    e6 = 64'h0102_0408_1020_4080;
    push_exp(e6, rev64(~e6));
    start = done_cnt[0];
    pulse_update();
    wait_done(start + 1);

    // Reset in the middle of the shift aborts the frame; a full frame follows
    raw_mode = 1'b0;
    dot_in   = 8'h00;
    data_in  = 32'hFEDC_BA98;
    e5 = 64'h7179_5E39_7C77_6F7F;
    push_exp(e5, rev64(~e5));
    pulse_update();
    t = 0;
    while (nbits[0] < 20 && t < 1000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("reach_bit20", 64'(nbits[0]), 64'd20);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_s_clk", 64'(sclk0), 64'd0);
    chk("abort_sout", 64'(sout0), 64'd0);
    chk("abort_s_clrn", 64'(sclrn0), 64'd0);
    chk("abort_en", 64'(en0), 64'd0);
    void'(q0.pop_front());
    void'(q1.pop_front());
    push_exp(e5, rev64(~e5));
    start = done_cnt[0];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_done(start + 1);
    @(negedge clk);
    chk("restart_en", 64'(en0), 64'd1);
    chk("queue_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
